// File: rtl/ram_port_arbiter.sv
// Two-requester OBI-style arbiter onto a single-port RAM with a round-robin priority pointer.
// Each grant enters a fixed-latency response pipeline that routes rvalid/rdata back to its owner.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH   = 22,
  parameter int MEM_AW       = 17,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  m0_req_i,
  output logic                  m0_gnt_o,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [31:0]           m0_wdata_i,
  output logic                  m0_rvalid_o,
  output logic [31:0]           m0_rdata_o,

  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [31:0]           m1_wdata_i,
  output logic                  m1_rvalid_o,
  output logic [31:0]           m1_rdata_o,

  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i,

  output logic                  oob_o,
  input  logic                  oob_clr_i
);

  localparam int LAST = READ_LATENCY - 1;

  logic                  prio_q;
  logic                  gnt0;
  logic                  gnt1;
  logic                  any_gnt;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_we;
  logic [3:0]            sel_be;
  logic [31:0]           sel_wdata;
  logic                  sel_oob;
  logic                  oob_q;

  logic [READ_LATENCY-1:0] pipe_valid_q;
  logic [READ_LATENCY-1:0] pipe_owner_q;
  logic [READ_LATENCY-1:0] pipe_oob_q;
  logic [READ_LATENCY-1:0] pipe_rd_q;

  // prio_q: 0 favours m0, 1 favours m1; grants are gated off while reset is asserted
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_ni) begin
      if (m0_req_i && (!m1_req_i || !prio_q)) begin
        gnt0 = 1'b1;
      end else if (m1_req_i) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign any_gnt  = gnt0 | gnt1;
  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_be    = 4'b0000;
    sel_wdata = 32'h0;
    if (gnt0) begin
      sel_addr  = m0_addr_i;
      sel_we    = m0_we_i;
      sel_be    = m0_be_i;
      sel_wdata = m0_wdata_i;
    end else if (gnt1) begin
      sel_addr  = m1_addr_i;
      sel_we    = m1_we_i;
      sel_be    = m1_be_i;
      sel_wdata = m1_wdata_i;
    end
  end

  generate
    if (MEM_AW < ADDR_WIDTH) begin : g_oob
      assign sel_oob = any_gnt & (|sel_addr[ADDR_WIDTH-1:MEM_AW]);
    end else begin : g_no_oob
      assign sel_oob = 1'b0;
    end
  endgenerate

  // Out-of-range accesses are still granted and returned, but never strobe the RAM
  assign ram_en_o    = any_gnt & ~sel_oob;
  assign ram_we_o    = sel_we & ~sel_oob;
  assign ram_addr_o  = sel_addr & ~ADDR_WIDTH'(3);
  assign ram_be_o    = sel_be;
  assign ram_wdata_o = sel_wdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= 1'b0;
    end else if (any_gnt) begin
      prio_q <= gnt0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oob_q <= 1'b0;
    end else if (sel_oob) begin
      oob_q <= 1'b1;
    end else if (oob_clr_i) begin
      oob_q <= 1'b0;
    end
  end

  assign oob_o = oob_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_valid_q <= '0;
      pipe_owner_q <= '0;
      pipe_oob_q   <= '0;
      pipe_rd_q    <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_owner_q[i] <= pipe_owner_q[i-1];
        pipe_oob_q[i]   <= pipe_oob_q[i-1];
        pipe_rd_q[i]    <= pipe_rd_q[i-1];
      end
      pipe_valid_q[0] <= any_gnt;
      pipe_owner_q[0] <= gnt1;
      pipe_oob_q[0]   <= sel_oob;
      pipe_rd_q[0]    <= any_gnt & ~sel_we;
    end
  end

  logic data_ok;
  assign data_ok     = pipe_rd_q[LAST] & ~pipe_oob_q[LAST];
  assign m0_rvalid_o = pipe_valid_q[LAST] & ~pipe_owner_q[LAST];
  assign m1_rvalid_o = pipe_valid_q[LAST] &  pipe_owner_q[LAST];
  assign m0_rdata_o  = (m0_rvalid_o && data_ok) ? ram_rdata_i : 32'h0;
  assign m1_rdata_o  = (m1_rvalid_o && data_ok) ? ram_rdata_i : 32'h0;

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 22, giving the requester and RAM address width in bits.
REQ-002 The module SHALL have parameter MEM_AW, default 17, giving the implemented RAM byte-address width (2**MEM_AW bytes).
REQ-003 The module SHALL have parameter READ_LATENCY, default 2, giving the RAM cycles from address to rdata (output register enabled); legal values are 1 to 4.
REQ-004 The module SHALL have one clock and an asynchronous active-low reset. The ports are clk_i (in, 1, clock) and rst_ni (in, 1, async active-low reset).
REQ-005 The module SHALL have these requester n ports, for n = 0 (core data) and n = 1 (loader/debug):
- mn_req_i, in, 1: request.
- mn_gnt_o, out, 1: grant.
- mn_addr_i, in, ADDR_WIDTH: byte address.
- mn_we_i, in, 1: write.
- mn_be_i, in, 4: byte enables.
- mn_wdata_i, in, 32: write data.
- mn_rvalid_o, out, 1: response valid.
- mn_rdata_o, out, 32: read data.
REQ-006 The module SHALL have these RAM-side ports:
- ram_en_o, out, 1: access strobe.
- ram_addr_o, out, ADDR_WIDTH: word-aligned address.
- ram_we_o, out, 1: write.
- ram_be_o, out, 4: byte enables.
- ram_wdata_o, out, 32: write data.
- ram_rdata_i, in, 32: read data.
REQ-007 The module SHALL have oob_o, out, 1: a sticky out-of-range access flag.
REQ-008 The module SHALL have oob_clr_i, in, 1: a synchronous clear for oob_o.

Function
REQ-009 Grant SHALL be combinational and in the same cycle as the request (OBI style); a transfer occurs when mn_req_i and mn_gnt_o are both high.
REQ-010 At most one of m0_gnt_o and m1_gnt_o SHALL be high in any cycle.
REQ-011 With a single requester active, that requester SHALL be granted in the same cycle, regardless of priority.
REQ-012 With both requesters active, the requester holding the priority pointer SHALL be granted.
REQ-013 After any grant, the priority pointer SHALL move to the requester that was not granted (round-robin); with no grant, the pointer SHALL hold.
REQ-014 In a grant cycle, the RAM outputs SHALL carry the winner's fields:
- ram_addr_o is the winner's address with bits [1:0] forced to 0.
- ram_we_o, ram_be_o and ram_wdata_o are the winner's values.
REQ-015 ram_en_o SHALL be 1 in a grant cycle, except for out-of-range accesses.
REQ-016 In a non-grant cycle, ram_en_o and ram_we_o SHALL be 0, and the other RAM outputs SHALL be 0.
REQ-017 An access SHALL be out-of-range when any address bit at or above MEM_AW is nonzero.
REQ-018 An out-of-range access SHALL still be granted, but with ram_en_o=0 and ram_we_o=0, and oob_o SHALL be set on the next edge.
REQ-019 oob_o SHALL stay high until oob_clr_i is sampled high; when a set and oob_clr_i occur in the same cycle, set SHALL win.
REQ-020 Each granted transfer (read or write) SHALL enter a response pipeline of READ_LATENCY stages, each stage holding {valid, owner, oob}.
REQ-021 mn_rvalid_o SHALL pulse for exactly one cycle, READ_LATENCY cycles after the grant cycle, for the owning requester only.
REQ-022 mn_rdata_o SHALL equal ram_rdata_i when mn_rvalid_o is high for an in-range read, and SHALL be 0 in all other cases (writes, out-of-range accesses, rvalid low).
REQ-023 The pipeline SHALL accept one new transfer every cycle; back-to-back grants SHALL produce back-to-back rvalids in grant order with no stall.
REQ-024 Requester inputs SHALL be ignored when the corresponding mn_req_i is low.

Reset
REQ-025 While rst_ni is low, the following SHALL hold:
- all pipeline valid bits are 0;
- the priority pointer selects m0;
- oob_o = 0;
- m0_rvalid_o and m1_rvalid_o = 0;
- m0_rdata_o and m1_rdata_o = 0.
REQ-026 While rst_ni is low, ram_en_o and ram_we_o SHALL be 0, and m0_gnt_o and m1_gnt_o SHALL be 0.
REQ-027 An assertion of rst_ni mid-operation SHALL discard all in-flight responses; no rvalid SHALL appear for transfers granted before reset.
REQ-028 The first cycle after reset release SHALL accept requests normally.

Verification
REQ-029 Single read: m0 reads 0x100 with the RAM word at 0x100 = 0xDEADBEEF -> m0_gnt_o=1 in the same cycle, ram_addr_o=0x100, m0_rvalid_o high exactly 2 cycles later with m0_rdata_o=0xDEADBEEF, and m1_rvalid_o stays 0.
REQ-030 Contention: m0 and m1 both request continuously for 4 cycles from reset -> grants go m0, m1, m0, m1, and the rvalids follow in the same order, each 2 cycles after its grant.
REQ-031 Write: m1 writes 0x12345678 with be=4'b0011 to addr 0x202 -> ram_addr_o=0x200, ram_we_o=1, ram_be_o=0011, m1_rvalid_o 2 cycles later with m1_rdata_o=0.
REQ-032 Out-of-range: m0 reads addr 0x20000 (MEM_AW=17) -> granted with ram_en_o=0, oob_o=1 from the next cycle, m0_rvalid_o after 2 cycles with rdata=0; oob_clr_i pulse -> oob_o=0.
REQ-033 Reset mid-flight: grant an m0 read, then drive rst_ni low 1 cycle later -> no m0_rvalid_o pulse, pointer at m0, and a request in the first cycle after release is granted.
REQ-034 Back-to-back: m0 issues 8 consecutive reads of 0x0, 0x4, ..., 0x1C -> 8 consecutive rvalid cycles starting 2 cycles after the first grant, with data in address order.
